// File: rtl/spike_aer_encoder_if.sv
// ---------------------------------------------------------------------------
// spike_aer_encoder_if
//   Valid/ready address-event stream leaving the spike AER encoder.
//
//   ev_valid  master -> slave  head event word is valid
//   ev_ready  slave  -> master consumer accepts the head event this cycle
//   ev_addr   master -> slave  neuron index of the head event
//   ev_ts     master -> slave  time-step stamp of the head event
// ---------------------------------------------------------------------------
interface spike_aer_encoder_if #(
    parameter int ADDR_W = 3,
    parameter int TS_W   = 16
);
    logic              ev_valid;
    logic              ev_ready;
    logic [ADDR_W-1:0] ev_addr;
    logic [TS_W-1:0]   ev_ts;

    modport master (output ev_valid, ev_addr, ev_ts, input ev_ready);
    modport slave  (input ev_valid, ev_addr, ev_ts, output ev_ready);
endinterface

// File: rtl/spike_aer_encoder.sv
// ---------------------------------------------------------------------------
// spike_aer_encoder
//   Turns per-neuron spike pulses into AER words {timestamp, address}.
//   Spikes are latched into a pending vector, one pending neuron is picked
//   per cycle by a round-robin arbiter, and the resulting event is pushed
//   into a small first-word-fall-through FIFO feeding a valid/ready stream.
//
//   clk         clock
//   reset_n     asynchronous active-low reset
//   spike_in    one bit per neuron, a 1 in any cycle is one spike
//   tick_in     single-cycle time-step strobe
//   ev          AER event stream (master side)
//   fifo_count  occupied FIFO entries
//   pending     latched spikes not yet encoded
//   drop_cnt    spikes merged into an already pending bit (saturating)
// ---------------------------------------------------------------------------
module spike_aer_encoder #(
    parameter int N_NEURONS  = 8,
    parameter int ADDR_W     = 3,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_NEURONS-1:0]          spike_in,
    input  logic                          tick_in,
    spike_aer_encoder_if.master           ev,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [N_NEURONS-1:0]          pending,
    output logic [DROP_W-1:0]             drop_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MRG_W = $clog2(N_NEURONS + 1);
    localparam int SUM_W = DROP_W + MRG_W;

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURONS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TS_W-1:0]                        ts_q, ts_d;
    logic [N_NEURONS-1:0]                   pending_q, pending_d;
    logic [ADDR_W-1:0]                      rr_ptr_q, rr_ptr_d;
    logic [DROP_W-1:0]                      drop_q, drop_d;

    logic [FIFO_DEPTH-1:0][ADDR_W-1:0]      mem_addr_q;
    logic [FIFO_DEPTH-1:0][TS_W-1:0]        mem_ts_q;
    logic [PTR_W-1:0]                       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                       count_q, count_d;
    logic [ADDR_W-1:0]                      head_addr_q, head_addr_d;
    logic [TS_W-1:0]                        head_ts_q, head_ts_d;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic                  fifo_full;
    logic                  grant;
    logic [ADDR_W-1:0]     gnt_idx;
    logic [N_NEURONS-1:0]  gnt_oh;
    logic [N_NEURONS-1:0]  merge;
    logic [MRG_W-1:0]      n_merge;
    logic [SUM_W-1:0]      drop_sum;
    logic                  push;
    logic                  pop;

    assign fifo_full = (count_q == CNT_FULL);

    // Round-robin search: walk N_NEURONS positions starting at rr_ptr and
    // take the first pending bit. A full FIFO blocks the grant entirely so
    // the pending bits simply keep accumulating.
    always_comb begin
        int unsigned idx;
        grant   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_NEURONS) idx = idx - N_NEURONS;
            if (!grant && pending_q[idx]) begin
                grant   = 1'b1;
                gnt_idx = ADDR_W'(idx);
            end
        end
        if (fifo_full) grant = 1'b0;
    end

    assign push = grant;
    assign pop  = (count_q != '0) && ev.ev_ready;

    // Pending update and merge accounting. A spike arriving on the bit being
    // granted re-arms it rather than counting as a merge.
    always_comb begin
        gnt_oh = '0;
        if (grant) gnt_oh[gnt_idx] = 1'b1;
        merge     = spike_in & pending_q & ~gnt_oh;
        pending_d = spike_in | (pending_q & ~gnt_oh);
        n_merge   = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            n_merge = n_merge + MRG_W'(merge[i]);
        end
        drop_sum = SUM_W'(drop_q) + SUM_W'(n_merge);
        drop_d   = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_W-1:0];
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + ADDR_W'(1);
    end

    assign ts_d = tick_in ? ts_q + TS_W'(1) : ts_q;

    // ------------------------------------------------------------------
    // FIFO pointers and count
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Head output register: preload the word that will be at the head after
    // this edge. When the write slot equals the next read slot the FIFO is
    // (or becomes) single-entry and the fresh event bypasses the memory.
    // An empty FIFO holds the last head value.
    always_comb begin
        head_addr_d = head_addr_q;
        head_ts_d   = head_ts_q;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_addr_d = gnt_idx;
                head_ts_d   = ts_q;
            end else begin
                head_addr_d = mem_addr_q[rd_ptr_d];
                head_ts_d   = mem_ts_q[rd_ptr_d];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q        <= '0;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            drop_q      <= '0;
            mem_addr_q  <= '0;
            mem_ts_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_addr_q <= '0;
            head_ts_q   <= '0;
        end else begin
            ts_q        <= ts_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            drop_q      <= drop_d;
            // The stamp is the counter value before this edge's tick.
            if (push) begin
                mem_addr_q[wr_ptr_q] <= gnt_idx;
                mem_ts_q[wr_ptr_q]   <= ts_q;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_addr_q <= head_addr_d;
            head_ts_q   <= head_ts_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ev.ev_valid = (count_q != '0);
    assign ev.ev_addr  = head_addr_q;
    assign ev.ev_ts    = head_ts_q;
    assign fifo_count  = count_q;
    assign pending     = pending_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// ---------------------------------------------------------------------------
// tb_spike_aer_encoder
//   Directed scenarios plus randomized traffic, compared every cycle against
//   an event-queue reference model of the encoder.
// ---------------------------------------------------------------------------
module tb_spike_aer_encoder;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int TW = 16;
    localparam int D  = 4;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic [N-1:0]         spike_in = '0;
    logic                 tick_in = 1'b0;
    logic [$clog2(D):0]   fifo_count;
    logic [N-1:0]         pending;
    logic [DW-1:0]        drop_cnt;

    spike_aer_encoder_if #(.ADDR_W(AW), .TS_W(TW)) ev_if ();

    spike_aer_encoder #(
        .N_NEURONS(N), .ADDR_W(AW), .TS_W(TW), .FIFO_DEPTH(D), .DROP_W(DW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spike_in   (spike_in),
        .tick_in    (tick_in),
        .ev         (ev_if),
        .fifo_count (fifo_count),
        .pending    (pending),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of events, a pending bit set, a pointer.
    typedef struct {
        int addr;
        int ts;
    } ev_t;

    ev_t          m_q[$];
    logic [N-1:0] m_pend;
    int           m_rr;
    logic [TW-1:0] m_ts;
    int           m_drop;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend = '0;
        m_rr   = 0;
        m_ts   = '0;
        m_drop = 0;
    endtask

    task automatic check_outputs();
        chk("ev_valid", 32'(ev_if.ev_valid), 32'(m_q.size() != 0));
        chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (m_q.size() != 0) begin
            chk("ev_addr", 32'(ev_if.ev_addr), 32'(m_q[0].addr));
            chk("ev_ts", 32'(ev_if.ev_ts), 32'(m_q[0].ts));
        end
    endtask

    // One clock edge of the encoder's behaviour, from the pre-edge state.
    task automatic model_step(input logic [N-1:0] sp, input logic tk, input logic rd);
        bit  pop;
        bit  gnt;
        int  g;
        ev_t e;
        pop = rd && (m_q.size() != 0);
        gnt = 0;
        g   = 0;
        if (m_pend != 0 && m_q.size() < D) begin
            for (int k = 0; k < N; k++) begin
                if (m_pend[(m_rr + k) % N]) begin
                    g   = (m_rr + k) % N;
                    gnt = 1;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (sp[i] && m_pend[i] && !(gnt && g == i))
                m_drop = (m_drop < (1 << DW) - 1) ? m_drop + 1 : m_drop;
        end
        if (gnt) m_pend[g] = 1'b0;
        m_pend = m_pend | sp;
        if (pop) void'(m_q.pop_front());
        if (gnt) begin
            e.addr = g;
            e.ts   = int'(m_ts);
            m_q.push_back(e);
            m_rr = (g + 1) % N;
        end
        if (tk) m_ts = m_ts + 1'b1;
    endtask

    task automatic cycle(input logic [N-1:0] sp, input logic tk, input logic rd);
        @(negedge clk);
        check_outputs();
        spike_in       = sp;
        tick_in        = tk;
        ev_if.ev_ready = rd;
        @(posedge clk);
        model_step(sp, tk, rd);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input bit pre_check);
        @(negedge clk);
        if (pre_check) check_outputs();
        #1;
        reset_n        = 1'b0;
        spike_in       = '0;
        tick_in        = 1'b0;
        ev_if.ev_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(ev_if.ev_valid), 32'd0);
        chk("rst_addr", 32'(ev_if.ev_addr), 32'd0);
        chk("rst_ts", 32'(ev_if.ev_ts), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        ev_if.ev_ready = 1'b0;
        model_reset();
        do_reset(1'b0);

        // Single spike on neuron 2 stamped at ts=5.
        repeat (5) cycle('0, 1'b1, 1'b0);
        cycle(8'h04, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b1);
        repeat (2) cycle('0, 1'b0, 1'b0);

        // All neurons at once with the consumer always ready.
        do_reset(1'b1);
        cycle(8'hFF, 1'b0, 1'b1);
        repeat (11) cycle('0, 1'b0, 1'b1);

        // Round-robin fairness after a grant on neuron 5.
        cycle(8'h20, 1'b0, 1'b1);
        repeat (3) cycle('0, 1'b0, 1'b1);
        cycle(8'h42, 1'b1, 1'b1);
        repeat (4) cycle('0, 1'b0, 1'b1);

        // Backpressure: six neurons, FIFO fills to four, then drain.
        cycle(8'h7E, 1'b0, 1'b0);
        repeat (8) cycle('0, 1'b0, 1'b0);
        repeat (10) cycle('0, 1'b0, 1'b1);

        // Merge while full, then a spike on the bit being granted.
        cycle(8'h0F, 1'b0, 1'b0);
        repeat (4) cycle('0, 1'b0, 1'b0);
        cycle(8'h08, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        cycle(8'h08, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        cycle(8'h08, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b1);
        cycle(8'h08, 1'b0, 1'b1);
        repeat (8) cycle('0, 1'b0, 1'b1);

        // Randomized traffic with sparse spikes, bursts and stalls.
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] sp;
            logic tk, rd;
            sp = N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 30) == 0) sp = N'($urandom);
            tk = ($urandom_range(0, 3) == 0);
            rd = ((c / 64) % 4 == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
            cycle(sp, tk, rd);
        end
        repeat (12) cycle('0, 1'b0, 1'b1);

        // Timestamp wrap and pre-increment stamping on a ticking push edge.
        while (m_ts != 16'hFFFE) cycle('0, 1'b1, 1'b1);
        cycle(8'h01, 1'b1, 1'b1);
        cycle('0, 1'b1, 1'b1);
        cycle(8'h80, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b1);
        repeat (3) cycle('0, 1'b0, 1'b1);

        // Reset with three buffered events and pending bits outstanding.
        cycle(8'hFF, 1'b1, 1'b0);
        repeat (3) cycle('0, 1'b0, 1'b0);
        do_reset(1'b1);
        repeat (3) cycle('0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
